// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core.
// Opcodes, R-type funct codes, the ALU operation encoding, and the decoded control bundle.
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // Decoded control for one instruction; all-zero means NOP.
    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    mem_to_reg;
        logic    use_imm;
        logic    dst_rt;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_alu_ctrl.sv
// Combinational decode, ALU and next-PC selection for one instruction.
// Ports: instr_i, pc_i, rs_data_i/rt_data_i operands; outputs ALU result (also the memory address),
//        register write enable/address, store enable, load-writeback select and the next PC.
module cpu_alu_ctrl
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]   instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic [XLEN-1:0]   rt_data_i,
    output logic [XLEN-1:0]   alu_res_c_o,
    output logic              reg_we_c_o,
    output logic [REG_AW-1:0] reg_waddr_c_o,
    output logic              mem_we_c_o,
    output logic              mem_to_reg_c_o,
    output logic [XLEN-1:0]   pc_next_c_o
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] pc_plus4;
    ctrl_t           ctrl;

    assign opcode   = instr_i[31:26];
    assign funct    = instr_i[5:0];
    assign imm_sext = sext16(instr_i[15:0]);
    assign pc_plus4 = pc_i + XLEN'(4);

    // Decode; unknown opcodes and functs fall through to the all-zero NOP bundle.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_we = 1'b1;
                case (funct)
                    FUNCT_ADD: ctrl.alu_op = ALU_ADD;
                    FUNCT_SUB: ctrl.alu_op = ALU_SUB;
                    FUNCT_AND: ctrl.alu_op = ALU_AND;
                    FUNCT_OR:  ctrl.alu_op = ALU_OR;
                    FUNCT_SLT: ctrl.alu_op = ALU_SLT;
                    default:   ctrl.reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_we  = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.dst_rt  = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_we     = 1'b1;
                ctrl.use_imm    = 1'b1;
                ctrl.dst_rt     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_we  = 1'b1;
                ctrl.use_imm = 1'b1;
            end
            OP_BEQ:  ctrl.branch = 1'b1;
            OP_J:    ctrl.jump   = 1'b1;
            default: ;
        endcase
    end

    // ALU
    always_comb begin
        alu_b = ctrl.use_imm ? imm_sext : rt_data_i;
        case (ctrl.alu_op)
            ALU_ADD: alu_res_c_o = rs_data_i + alu_b;
            ALU_SUB: alu_res_c_o = rs_data_i - alu_b;
            ALU_AND: alu_res_c_o = rs_data_i & alu_b;
            ALU_OR:  alu_res_c_o = rs_data_i | alu_b;
            ALU_SLT: alu_res_c_o = XLEN'($signed(rs_data_i) < $signed(alu_b));
            default: alu_res_c_o = rs_data_i + alu_b;
        endcase
    end

    // Next PC: jump, taken branch, or sequential
    always_comb begin
        pc_next_c_o = pc_plus4;
        if (ctrl.jump) begin
            pc_next_c_o = {pc_plus4[31:28], instr_i[25:0], 2'b00};
        end else if (ctrl.branch && (rs_data_i == rt_data_i)) begin
            pc_next_c_o = pc_plus4 + (imm_sext << 2);
        end
    end

    assign reg_we_c_o     = ctrl.reg_we;
    assign reg_waddr_c_o  = ctrl.dst_rt ? instr_i[20:16] : instr_i[15:11];
    assign mem_we_c_o     = ctrl.mem_we;
    assign mem_to_reg_c_o = ctrl.mem_to_reg;

endmodule

// File: rtl/cpu_dmem.sv
// Data memory: combinational word read, word write on the rising edge.
// Ports: clk_i, addr_i byte address (low two bits ignored, wraps modulo WORDS),
//        we_i/wdata_i store port, rdata_c_o load data.
module cpu_dmem
    import cpu_pkg::*;
#(
    parameter int unsigned WORDS = 256
) (
    input  logic            clk_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_c_o
);

    localparam int unsigned AW = $clog2(WORDS);

    logic [XLEN-1:0] data [0:WORDS-1] = '{default: '0};
    logic [XLEN-1:0] word_idx;

    assign word_idx  = (addr_i >> 2) % XLEN'(WORDS);
    assign rdata_c_o = data[AW'(word_idx)];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data[AW'(word_idx)] <= wdata_i;
        end
    end

endmodule

// File: rtl/cpu_imem.sv
// Instruction memory, loaded hierarchically; combinational word read.
// Ports: addr_i byte address (low two bits ignored, wraps modulo WORDS), rdata_c_o instruction word.
module cpu_imem
    import cpu_pkg::*;
#(
    parameter int unsigned WORDS = 256
) (
    input  logic [XLEN-1:0] addr_i,
    output logic [XLEN-1:0] rdata_c_o
);

    localparam int unsigned AW = $clog2(WORDS);

    logic [XLEN-1:0] data [0:WORDS-1] = '{default: '0};
    logic [XLEN-1:0] word_idx;

    assign word_idx  = (addr_i >> 2) % XLEN'(WORDS);
    assign rdata_c_o = data[AW'(word_idx)];

endmodule

// File: rtl/cpu_pc.sv
// Program counter register.
// Ports: clk_i, rst_i (async, active-high), pc_d_i next PC, pc_o current PC.
module cpu_pc
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_d_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_d_i;
        end
    end

    assign pc_o = pc_reg;

endmodule

// File: rtl/cpu_regfile.sv
// 32 x 32 register file: two combinational read ports, one write port on the rising edge.
// Ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_a_i/raddr_b_i reads,
//        rdata_a_c_o/rdata_b_c_o combinational read data. Register 0 is hardwired to zero.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_a_c_o,
    output logic [XLEN-1:0]   rdata_b_c_o
);

    logic [XLEN-1:0] register_file [0:NUM_REGS-1] = '{default: '0};

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            register_file[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_c_o = (raddr_a_i == '0) ? '0 : register_file[raddr_a_i];
    assign rdata_b_c_o = (raddr_b_i == '0) ? '0 : register_file[raddr_b_i];

endmodule

// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset core with internal instruction and data memories.
// Ports: clock, reset (async, active-high). Instances pc, regfile, instruction_memory and
// data_memory are accessed hierarchically to load programs and observe state.
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256
) (
    input logic clock,
    input logic reset
);

    logic [XLEN-1:0]   pc_cur;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   dmem_rdata;
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] reg_waddr;
    logic              reg_we;
    logic              mem_we;
    logic              mem_to_reg;

    cpu_pc pc (
        .clk_i  (clock),
        .rst_i  (reset),
        .pc_d_i (pc_next),
        .pc_o   (pc_cur)
    );

    cpu_imem #(.WORDS(IMEM_WORDS)) instruction_memory (
        .addr_i    (pc_cur),
        .rdata_c_o (instr)
    );

    // Writes are blocked while reset is held so the in-progress edge has no side effects.
    cpu_regfile regfile (
        .clk_i       (clock),
        .we_i        (reg_we & ~reset),
        .waddr_i     (reg_waddr),
        .wdata_i     (wb_data),
        .raddr_a_i   (instr[25:21]),
        .raddr_b_i   (instr[20:16]),
        .rdata_a_c_o (rs_data),
        .rdata_b_c_o (rt_data)
    );

    cpu_alu_ctrl alu_ctrl (
        .instr_i        (instr),
        .pc_i           (pc_cur),
        .rs_data_i      (rs_data),
        .rt_data_i      (rt_data),
        .alu_res_c_o    (alu_res),
        .reg_we_c_o     (reg_we),
        .reg_waddr_c_o  (reg_waddr),
        .mem_we_c_o     (mem_we),
        .mem_to_reg_c_o (mem_to_reg),
        .pc_next_c_o    (pc_next)
    );

    cpu_dmem #(.WORDS(DMEM_WORDS)) data_memory (
        .clk_i     (clock),
        .addr_i    (alu_res),
        .we_i      (mem_we & ~reset),
        .wdata_i   (rt_data),
        .rdata_c_o (dmem_rdata)
    );

    assign wb_data = mem_to_reg ? dmem_rdata : alu_res;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed program scenarios plus random programs checked
// against an instruction-level reference model.
module tb_cpu;

    localparam int unsigned IMEM_WORDS = 256;
    localparam int unsigned DMEM_WORDS = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_reg  [32];
    logic [31:0] m_mem  [DMEM_WORDS];
    logic [31:0] m_imem [IMEM_WORDS];
    logic [31:0] m_pc;

    cpu #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_word(input int unsigned idx, input logic [31:0] w);
        dut.instruction_memory.data[idx] = w;
        m_imem[idx] = w;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < IMEM_WORDS; i++) load_word(i, 32'h0);
    endtask

    task automatic test_reset();
        begin_reset();
        clear_imem();
        #1;
        n_checks++;
        if (dut.pc.pc_reg !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", dut.pc.pc_reg, 32'h0);
        end
        end_reset();
        n_checks++;
        if (dut.pc.pc_reg !== 32'h0) begin
            n_fail++; $display("FAIL reset_held_pc: got %h expected %h", dut.pc.pc_reg, 32'h0);
        end
        tick();
        n_checks++;
        if (dut.pc.pc_reg !== 32'h4) begin
            n_fail++; $display("FAIL first_edge_pc: got %h expected %h", dut.pc.pc_reg, 32'h4);
        end
    endtask

    task automatic test_arith_mem();
        logic [31:0] prog [10] = '{32'h20080006, 32'h2009000B, 32'h2108000A, 32'h212A00F0,
                                   32'h01095020, 32'h20080005, 32'h20090009, 32'hAC080000,
                                   32'hAC090004, 32'h8C080004};
        bit          is_mem [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        int unsigned idx    [10] = '{8, 9, 8, 10, 10, 8, 9, 0, 1, 8};
        logic [31:0] expv   [10] = '{32'd6, 32'd11, 32'd16, 32'd251, 32'd27,
                                     32'd5, 32'd9, 32'd5, 32'd9, 32'd9};
        logic [31:0] got;
        begin_reset();
        clear_imem();
        for (int i = 0; i < 10; i++) load_word(i, prog[i]);
        end_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            got = is_mem[k] ? dut.data_memory.data[idx[k]] : dut.regfile.register_file[idx[k]];
            n_checks++;
            if (got !== expv[k]) begin
                n_fail++; $display("FAIL arith_mem_step[%0d]: got %h expected %h", k, got, expv[k]);
            end
            n_checks++;
            if (dut.pc.pc_reg !== 32'(4 * (k + 1))) begin
                n_fail++; $display("FAIL arith_mem_pc[%0d]: got %h expected %h", k, dut.pc.pc_reg, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_zero_reg();
        begin_reset();
        clear_imem();
        load_word(0, 32'h20000007);
        end_reset();
        tick();
        n_checks++;
        if (dut.regfile.register_file[0] !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg: got %h expected %h", dut.regfile.register_file[0], 32'h0);
        end
        n_checks++;
        if (dut.pc.pc_reg !== 32'h4) begin
            n_fail++; $display("FAIL zero_reg_pc: got %h expected %h", dut.pc.pc_reg, 32'h4);
        end
    endtask

    task automatic test_branch_jump();
        begin_reset();
        clear_imem();
        load_word(0, 32'h1000FFFF);
        end_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (dut.pc.pc_reg !== 32'h0) begin
                n_fail++; $display("FAIL beq_self_pc[%0d]: got %h expected %h", k, dut.pc.pc_reg, 32'h0);
            end
        end
        @(negedge clock);
        load_word(0, 32'h08000004);
        tick();
        n_checks++;
        if (dut.pc.pc_reg !== 32'd16) begin
            n_fail++; $display("FAIL jump_pc: got %h expected %h", dut.pc.pc_reg, 32'd16);
        end
    endtask

    task automatic test_reset_mid();
        begin_reset();
        clear_imem();
        load_word(0, 32'h20080011);  // addi $t0,$0,0x11
        load_word(1, 32'hAC080040);  // sw   $t0,0x40($0)
        load_word(2, 32'h20080055);  // addi $t0,$0,0x55
        end_reset();
        repeat (3) tick();
        n_checks++;
        if (dut.data_memory.data[16] !== 32'h11) begin
            n_fail++; $display("FAIL mid_pre_store: got %h expected %h", dut.data_memory.data[16], 32'h11);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut.pc.pc_reg !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_pc: got %h expected %h", dut.pc.pc_reg, 32'h0);
        end
        tick();  // word 0 (addi $t0) must not write during reset
        n_checks++;
        if (dut.regfile.register_file[8] !== 32'h55) begin
            n_fail++; $display("FAIL mid_reset_reg_hold: got %h expected %h", dut.regfile.register_file[8], 32'h55);
        end
        @(negedge clock);
        load_word(0, 32'hAC080040);  // a store at word 0 must not write during reset
        tick();
        n_checks++;
        if (dut.data_memory.data[16] !== 32'h11) begin
            n_fail++; $display("FAIL mid_reset_no_store: got %h expected %h", dut.data_memory.data[16], 32'h11);
        end
        n_checks++;
        if (dut.pc.pc_reg !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_held_pc: got %h expected %h", dut.pc.pc_reg, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        n_checks++;
        if (dut.data_memory.data[16] !== 32'h55) begin
            n_fail++; $display("FAIL restart_store: got %h expected %h", dut.data_memory.data[16], 32'h55);
        end
        n_checks++;
        if (dut.pc.pc_reg !== 32'h4) begin
            n_fail++; $display("FAIL restart_pc: got %h expected %h", dut.pc.pc_reg, 32'h4);
        end
    endtask

    // Execute one instruction in the reference model, straight from the ISA definition.
    task automatic model_step();
        logic [31:0] ins, a, b, imm, pc4, nxt, wv, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, wi;
        bit          wr;
        ins = m_imem[(m_pc >> 2) % IMEM_WORDS];
        op  = ins[31:26]; fn = ins[5:0];
        rs  = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        a   = m_reg[rs];  b  = m_reg[rt];
        imm = {{16{ins[15]}}, ins[15:0]};
        pc4 = m_pc + 32'd4;
        nxt = pc4; wr = 0; wi = rd; wv = 32'h0;
        ea  = a + imm;
        case (op)
            6'h00: begin
                wr = 1;
                case (fn)
                    6'h20: wv = a + b;
                    6'h22: wv = a - b;
                    6'h24: wv = a & b;
                    6'h25: wv = a | b;
                    6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 0;
                endcase
            end
            6'h08: begin wr = 1; wi = rt; wv = a + imm; end
            6'h23: begin wr = 1; wi = rt; wv = m_mem[(ea >> 2) % DMEM_WORDS]; end
            6'h2B: m_mem[(ea >> 2) % DMEM_WORDS] = b;
            6'h04: if (a == b) nxt = pc4 + (imm << 2);
            6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr && wi != 0) m_reg[wi] = wv;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_instr(input int unsigned body_lo, input int unsigned body_hi);
        logic [5:0]  functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        logic [5:0]  junk   [5] = '{6'h0D, 6'h0F, 6'h03, 6'h05, 6'h2A};
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, functs[$urandom_range(0, 5)]};
            3:       return {6'h08, rs, rt, imm};
            4:       return {6'h23, 5'd0, rt, 16'(256 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3))};
            5:       return {6'h2B, 5'd0, rt, 16'(256 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3))};
            6:       return {6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, 16'($urandom_range(1, 3))};
            7:       return {6'h02, 26'($urandom_range(body_lo, body_hi))};
            8:       return {junk[$urandom_range(0, 4)], 26'($urandom)};
            default: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
        endcase
    endfunction

    task automatic test_random_program();
        int unsigned n;
        for (int iter = 0; iter < 3; iter++) begin
            begin_reset();
            clear_imem();
            for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
            for (int i = 0; i < DMEM_WORDS; i++) m_mem[i] = 32'h0;
            n = 0;
            for (int k = 1; k < 32; k++) begin
                load_word(n, {6'h08, 5'd0, 5'(k), 16'($urandom)});
                n++;
            end
            for (int i = 0; i < 8; i++) begin
                load_word(n, {6'h2B, 5'd0, 5'(i + 1), 16'(256 + 4 * i)});
                n++;
            end
            for (int i = 0; i < 40; i++) load_word(n + i, rand_instr(n, n + 39));
            end_reset();
            m_pc = 32'h0;
            for (int c = 0; c < 200; c++) begin
                model_step();
                tick();
                n_checks++;
                if (dut.pc.pc_reg !== m_pc) begin
                    n_fail++; $display("FAIL rand_pc[%0d.%0d]: got %h expected %h", iter, c, dut.pc.pc_reg, m_pc);
                end
            end
            for (int r = 0; r < 32; r++) begin
                n_checks++;
                if (dut.regfile.register_file[r] !== m_reg[r]) begin
                    n_fail++; $display("FAIL rand_reg[%0d.%0d]: got %h expected %h", iter, r, dut.regfile.register_file[r], m_reg[r]);
                end
            end
            for (int i = 64; i < 72; i++) begin
                n_checks++;
                if (dut.data_memory.data[i] !== m_mem[i]) begin
                    n_fail++; $display("FAIL rand_mem[%0d.%0d]: got %h expected %h", iter, i, dut.data_memory.data[i], m_mem[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith_mem();
        test_zero_reg();
        test_branch_jump();
        test_reset_mid();
        test_random_program();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
